fifo_rd_ctrl: RTL and testbench

Read-side controller for the FIFO memory. It owns the read pointer and drives the memory's `rd_addr`, and it captures the memory's asynchronous `rd_data` into a registered valid/ready output stage. It generates `empty` and occupancy from a write pointer that has already been Gray-synchronised into this clock domain. It also exports its own Gray read pointer for synchronisation back to the write side.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_rd_ctrl_if.sv | 9 +
 rtl/fifo_gray2bin.sv | 11 +
 rtl/fifo_rd_ctrl.sv | 55 +++++
 tb/tb_fifo_rd_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO constants and Gray/binary pointer helpers, used by both read and write controllers.
package fifo_pkg;
  localparam int ADDR_SIZE_DEF = 4;
  localparam int DATA_SIZE_DEF = 8;
  localparam int PTR_W_MAX     = 32;

  typedef logic [PTR_W_MAX-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extended narrow pointers convert unchanged.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
    for (int i = PTR_W_MAX-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Valid/ready output stream of the FIFO read controller.
interface fifo_rd_ctrl_if #(parameter int DATA_SIZE = fifo_pkg::DATA_SIZE_DEF);
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_SIZE-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter of parameterised width.
module fifo_gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end
endmodule

// File: rtl/fifo_rd_ctrl.sv
// FIFO read-side controller: read pointer, empty/level from the synchronised write pointer,
// and a registered valid/ready output stage fed from the memory's async read port.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int DATA_SIZE = DATA_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_SIZE:0]   wr_ptr_gray_sync,
  output logic [ADDR_SIZE-1:0] rd_addr,
  input  logic [DATA_SIZE-1:0] rd_data,
  output logic [ADDR_SIZE:0]   rd_ptr_gray,
  output logic                 empty,
  output logic [ADDR_SIZE:0]   level,
  fifo_rd_ctrl_if.master       out
);
  localparam int PW = ADDR_SIZE + 1;

  logic [PW-1:0] rd_bin, rd_bin_nxt, rd_gray_nxt, wr_bin;
  logic          pop;

  assign rd_bin_nxt  = rd_bin + 1'b1;
  assign rd_gray_nxt = PW'(bin2gray(ptr_t'(rd_bin_nxt)));
  assign rd_addr     = rd_bin[ADDR_SIZE-1:0];

  // Both pointers are Gray, so equality needs no conversion.
  assign empty = (rd_ptr_gray == wr_ptr_gray_sync);
  assign pop   = !empty && (!out.out_valid || out.out_ready);

  fifo_gray2bin #(.W(PW)) u_wr_g2b (
    .gray (wr_ptr_gray_sync),
    .bin  (wr_bin)
  );

  assign level = wr_bin - rd_bin;

  // Gray pointer is registered from rd_bin+1 so it never glitches toward the write domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_bin        <= '0;
      rd_ptr_gray   <= '0;
      out.out_valid <= 1'b0;
      out.out_data  <= '0;
    end else if (pop) begin
      rd_bin        <= rd_bin_nxt;
      rd_ptr_gray   <= rd_gray_nxt;
      out.out_valid <= 1'b1;
      out.out_data  <= rd_data;
    end else if (out.out_valid && out.out_ready) begin
      out.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: count-based reference model compared every cycle, plus directed literal checks.
module tb_fifo_rd_ctrl;
  localparam int AW = 4, DW = 8, DEPTH = 16;

  logic          clk = 1'b0, rst = 1'b0;
  logic [AW:0]   wr_ptr_gray_sync = '0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [AW:0]   rd_ptr_gray, level;
  logic          empty;

  fifo_rd_ctrl_if #(.DATA_SIZE(DW)) out_if();

  fifo_rd_ctrl #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
    .clk              (clk),
    .rst              (rst),
    .wr_ptr_gray_sync (wr_ptr_gray_sync),
    .rd_addr          (rd_addr),
    .rd_data          (rd_data),
    .rd_ptr_gray      (rd_ptr_gray),
    .empty            (empty),
    .level            (level),
    .out              (out_if)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  assign rd_data = mem[rd_addr];

  int errors = 0, checks = 0;

  // Reference model: counts of words written and popped, plus the staged word.
  int            m_wr = 0, m_rd = 0;
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic [DW-1:0] wdata [1024];
  logic          chk_en = 1'b0;

  function automatic logic [AW:0] g5(input int b);
    logic [AW:0] x;
    x = b[AW:0];
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_rd    <= 0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if ((m_wr - m_rd) > 0 && (!m_valid || out_if.out_ready)) begin
      m_data  <= wdata[m_rd];
      m_valid <= 1'b1;
      m_rd    <= m_rd + 1;
    end else if (m_valid && out_if.out_ready) begin
      m_valid <= 1'b0;
    end
  end

  logic [AW:0]   prev_gray;
  logic [AW-1:0] prev_addr;
  logic          have_prev = 1'b0, saw_addr_wrap = 1'b0, saw_bin_wrap = 1'b0;

  always @(negedge clk) begin
    if (!rst || !chk_en) begin
      have_prev <= 1'b0;
    end else begin
      chk("out_valid", 32'(out_if.out_valid), 32'(m_valid));
      chk("out_data", 32'(out_if.out_data), 32'(m_data));
      chk("empty", 32'(empty), 32'(m_wr == m_rd));
      chk("level", 32'(level), m_wr - m_rd);
      chk("rd_addr", 32'(rd_addr), m_rd % DEPTH);
      chk("rd_ptr_gray", 32'(rd_ptr_gray), 32'(g5(m_rd)));
      if (have_prev && rd_ptr_gray != prev_gray)
        chk("gray_onebit", $countones(rd_ptr_gray ^ prev_gray), 1);
      if (have_prev && prev_addr == 4'd15 && rd_addr == 4'd0) saw_addr_wrap <= 1'b1;
      if (have_prev && prev_gray == 5'b10000 && rd_ptr_gray == 5'd0) saw_bin_wrap <= 1'b1;
      prev_gray <= rd_ptr_gray;
      prev_addr <= rd_addr;
      have_prev <= 1'b1;
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    mem[m_wr % DEPTH] = d;
    wdata[m_wr]       = d;
    m_wr              = m_wr + 1;
    wr_ptr_gray_sync  = g5(m_wr);
  endtask

  task automatic do_reset();
    chk_en           = 1'b0;
    rst              = 1'b0;
    m_wr             = 0;
    wr_ptr_gray_sync = '0;
    out_if.out_ready = 1'b0;
    repeat (2) step();
    rst    = 1'b1;
    chk_en = 1'b1;
  endtask

  logic [DW-1:0] got_q[$];

  initial begin
    foreach (mem[i]) mem[i] = '0;
    out_if.out_ready = 1'b0;

    // Reset state
    do_reset();
    #1;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_level", 32'(level), 0);
    chk("rst_valid", 32'(out_if.out_valid), 0);
    chk("rst_addr", 32'(rd_addr), 0);
    chk("rst_gray", 32'(rd_ptr_gray), 0);

    // Single word with consumer stalled
    step();
    write_word(8'hA5);
    #1;
    chk("sw_empty_fall", 32'(empty), 0);
    chk("sw_level", 32'(level), 1);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("sw_valid", 32'(out_if.out_valid), 1);
      chk("sw_data", 32'(out_if.out_data), 32'h A5);
      chk("sw_gray", 32'(rd_ptr_gray), 1);
      chk("sw_empty", 32'(empty), 1);
    end
    out_if.out_ready = 1'b1;
    step();
    chk("sw_accepted", 32'(out_if.out_valid), 0);

    // Burst with consumer always ready
    do_reset();
    out_if.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) write_word(8'(8'h10 + k));
    #1;
    chk("burst_level0", 32'(level), 4);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("burst_data", 32'(out_if.out_data), 32'(8'h10 + k));
      chk("burst_level", 32'(level), 3 - k);
    end

    // Backpressure: ready toggles, collect every accepted word
    do_reset();
    for (int k = 0; k < 4; k++) write_word(8'(8'h20 + k));
    got_q.delete();
    for (int k = 0; k < 12; k++) begin
      out_if.out_ready = (k % 2 == 0);
      #1;
      if (out_if.out_valid && out_if.out_ready) got_q.push_back(out_if.out_data);
      step();
    end
    chk("bp_count", got_q.size(), 4);
    for (int k = 0; k < 4 && k < got_q.size(); k++)
      chk("bp_word", 32'(got_q[k]), 32'(8'h20 + k));

    // Wrap: 40 words through a 16-deep memory
    do_reset();
    for (int c = 0; c < 600 && m_rd < 40; c++) begin
      out_if.out_ready = ($urandom_range(0, 3) != 0);
      if ((m_wr - m_rd) < DEPTH && m_wr < 40 && $urandom_range(0, 2) != 0)
        write_word(8'($urandom));
      step();
    end
    chk("wrap_popped", 32'(m_rd >= 40), 1);
    out_if.out_ready = 1'b0;
    step();
    step();
    for (int k = 0; k < DEPTH && (m_wr - m_rd) < DEPTH; k++) write_word(8'($urandom));
    #1;
    chk("full_level", 32'(level), 16);
    chk("full_empty", 32'(empty), 0);
    step();
    chk("addr_wrapped", 32'(saw_addr_wrap), 1);
    chk("bin_wrapped", 32'(saw_bin_wrap), 1);
    out_if.out_ready = 1'b1;
    repeat (20) step();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      out_if.out_ready = ($urandom_range(0, 1) != 0);
      if ((m_wr - m_rd) < DEPTH && m_wr < 1000 && $urandom_range(0, 1) != 0)
        write_word(8'($urandom));
      step();
    end

    // Reset mid-stream with a staged word
    out_if.out_ready = 1'b0;
    if ((m_wr - m_rd) < DEPTH) write_word(8'h5A);
    for (int c = 0; c < 5 && !out_if.out_valid; c++) step();
    chk("mid_staged", 32'(out_if.out_valid), 1);
    chk_en = 1'b0;
    rst    = 1'b0;
    #1;
    chk("mid_valid_drop", 32'(out_if.out_valid), 0);
    chk("mid_gray", 32'(rd_ptr_gray), 0);
    m_wr             = 0;
    wr_ptr_gray_sync = '0;
    step();
    rst    = 1'b1;
    chk_en = 1'b1;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
